// File: rtl/led_fade_pkg.sv
// Shared defaults and helper functions for the LED afterglow stage.
// LED_FADE_GAMMA_EN selects the square-law brightness map in led_fade_chan.
package led_fade_pkg;

  localparam int DEF_N_LEDS     = 12;
  localparam int DEF_PWM_BITS   = 8;
  localparam int DEF_DECAY_DIV  = 65536;
  localparam int DEF_DECAY_STEP = 8;

  function automatic int full_level(input int bits);
    return (1 << bits) - 1;
  endfunction

  // Square-law map: product kept at double width, upper half returned.
  function automatic logic [31:0] gamma_map(input logic [31:0] lvl, input int bits);
    logic [63:0] prod;
    prod = {32'd0, lvl} * {32'd0, lvl};
    return 32'(prod >> bits);
  endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One afterglow channel: brightness level with saturating decay, optional
// gamma (LED_FADE_GAMMA_EN) and the registered PWM comparator.
module led_fade_chan
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int DECAY_STEP = DEF_DECAY_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pat_i,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o
);

  localparam logic [PWM_BITS-1:0] FULL = PWM_BITS'(full_level(PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty;
  logic                led_q, led_d;

  // A high pattern bit outranks a coincident decay tick.
  always_comb begin
    level_d = level_q;
    if (pat_i) begin
      level_d = FULL;
    end else if (tick_i) begin
      level_d = (level_q >= STEP) ? (level_q - STEP) : '0;
    end
  end

`ifdef LED_FADE_GAMMA_EN
  assign duty = PWM_BITS'(gamma_map(32'(level_q), PWM_BITS));
`else
  assign duty = level_q;
`endif

  assign led_d = (duty > pwm_cnt_i);
  assign led_o = led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: rtl/led_fade.sv
// LED afterglow top: decay prescaler, shared PWM counter, per-LED channels.
// Define LED_FADE_GAMMA_EN for gamma-corrected duty.
module led_fade
  import led_fade_pkg::*;
#(
  parameter int N_LEDS     = DEF_N_LEDS,
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int DECAY_DIV  = DEF_DECAY_DIV,
  parameter int DECAY_STEP = DEF_DECAY_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LEDS-1:0] pattern,
  output logic [N_LEDS-1:0] led,
  output logic              tick
);

  localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  // With DECAY_DIV = 1 the counter sits at 0 and tick is permanently high.
  assign tick      = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = tick ? '0 : (div_cnt_q + 1'b1);
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
    led_fade_chan #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .pat_i    (pattern[i]),
      .tick_i   (tick),
      .pwm_cnt_i(pwm_cnt_q),
      .led_o    (led[i])
    );
  end

endmodule

// File: tb/tb_led_fade.sv
// Bench for led_fade: two instances (decay step 5 and 4) against a
// cycle-count based reference model, with directed and random patterns.
module tb_led_fade;

  localparam int N      = 12;
  localparam int PB     = 4;
  localparam int DIV    = 4;
  localparam int STEP_A = 5;
  localparam int STEP_B = 4;
  localparam int FULL   = 15;
  localparam int PERIOD = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  pattern = '0;
  logic [N-1:0]  led_a, led_b;
  logic          tick_a, tick_b;

  int total = 0;
  int bad   = 0;
  int lvl_a [N];
  int lvl_b [N];
  int cyc;

  always #5 clk = ~clk;

  led_fade #(.N_LEDS(N), .PWM_BITS(PB), .DECAY_DIV(DIV), .DECAY_STEP(STEP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .pattern(pattern), .led(led_a), .tick(tick_a));

  led_fade #(.N_LEDS(N), .PWM_BITS(PB), .DECAY_DIV(DIV), .DECAY_STEP(STEP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .pattern(pattern), .led(led_b), .tick(tick_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int duty_of(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l) >> PB;
`else
    return l;
`endif
  endfunction

  function automatic int decay(input int l, input int step);
    return (l >= step) ? l - step : 0;
  endfunction

  // cyc = number of clock edges since reset release; counters are cyc mod period.
  task automatic step(input logic [N-1:0] p);
    logic [N-1:0] exp_a, exp_b;
    bit           t;
    pattern = p;
    @(posedge clk);
    t = ((cyc % DIV) == DIV - 1);
    for (int i = 0; i < N; i++) begin
      exp_a[i] = (duty_of(lvl_a[i]) > (cyc % PERIOD));
      exp_b[i] = (duty_of(lvl_b[i]) > (cyc % PERIOD));
      if (p[i]) begin
        lvl_a[i] = FULL;
        lvl_b[i] = FULL;
      end else if (t) begin
        lvl_a[i] = decay(lvl_a[i], STEP_A);
        lvl_b[i] = decay(lvl_b[i], STEP_B);
      end
    end
    cyc++;
    #1;
    check("led_a", 32'(led_a), 32'(exp_a));
    check("led_b", 32'(led_b), 32'(exp_b));
    check("tick", {30'd0, tick_b, tick_a}, ((cyc % DIV) == DIV - 1) ? 32'd3 : 32'd0);
  endtask

  // Asynchronous reset asserted between edges, released mid-cycle.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_led", {20'd0, led_b, led_a}, 32'd0);
    check("rst_tick", {30'd0, tick_b, tick_a}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      lvl_a[i] = 0;
      lvl_b[i] = 0;
    end
  endtask

  initial begin
    int found;
    int hold;
    logic [N-1:0] p;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      lvl_a[i] = 0;
      lvl_b[i] = 0;
    end
    #1;
    check("por_led", {20'd0, led_b, led_a}, 32'd0);
    check("por_tick", {30'd0, tick_b, tick_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle, then stuck-high on LED0, then full decay (both step sizes).
    for (int k = 0; k < 8; k++) step('0);
    for (int k = 0; k < 40; k++) step(12'h001);
    for (int k = 0; k < 40; k++) step('0);

    // Re-trigger in the same cycle as a tick while level is 10.
    for (int k = 0; k < 8; k++) step(12'h001);
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      if (((cyc % DIV) == DIV - 1) && lvl_a[0] == 10) found = 1;
      else step('0);
    end
    check("retrig_found", 32'(found), 32'd1);
    step(12'h001);
    for (int k = 0; k < 20; k++) step('0);

    // Reset in the middle of a fade and mid PWM period.
    for (int k = 0; k < 10; k++) step(12'hfff);
    for (int k = 0; k < 7; k++) step('0);
    do_reset();
    for (int k = 0; k < 20; k++) step('0);

    // Random sparse patterns held for random lengths, occasional reset.
    p = '0;
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        p = N'($urandom & $urandom & $urandom);
        hold = $urandom_range(1, 60);
      end
      hold--;
      step(p);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_fade.md
# led_fade

Downstream stage of the LED chaser. It takes the 12-bit on/off pattern produced by `trail` and turns each LED into an afterglow channel. When a bit is high, that LED runs at full brightness. When the bit drops, the LED fades linearly to dark. Brightness is delivered through per-LED PWM, and the block drives the board `led[11:0]` pins in place of the raw pattern.

## Interface
- `N_LEDS`, default 12: number of LED channels.
- `PWM_BITS`, default 8: brightness and PWM counter width.
- `DECAY_DIV`, default 65536: clocks per decay tick; minimum 1.
- `DECAY_STEP`, default 8: brightness subtracted per decay tick; range 1..2^PWM_BITS−1.
- `clk`, input, 1: system clock. One clock domain only.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `pattern`, input, N_LEDS: on/off pattern from `trail`. It is synchronous to `clk`.
- `led`, output, N_LEDS: PWM-modulated LED drive, registered.
- `tick`, output, 1: single-cycle pulse on each decay tick, for debug and test.

## Operation
- **Prescaler**
  - Counter `div_cnt` counts 0..DECAY_DIV−1 and wraps to 0.
  - `tick` is high for exactly the one cycle in which `div_cnt == DECAY_DIV−1`.
  - If DECAY_DIV = 1, `tick` is high every cycle.
- **Brightness register.** Each channel i has a register `level[i]` of width PWM_BITS. On each clock edge:
  - If `pattern[i]` = 1: `level[i]` ← 2^PWM_BITS−1 (full). This wins over a simultaneous tick.
  - Else if `tick` = 1 and `level[i]` ≥ DECAY_STEP: `level[i]` ← `level[i]` − DECAY_STEP.
  - Else if `tick` = 1 and `level[i]` < DECAY_STEP: `level[i]` ← 0. The subtraction saturates and never wraps.
  - Otherwise `level[i]` holds its value.
- **PWM**
  - One shared counter `pwm_cnt` (PWM_BITS wide) increments every cycle and wraps from 2^PWM_BITS−1 to 0.
  - The next value of `led[i]` is `duty[i] > pwm_cnt`, using an unsigned compare.
  - `duty[i]` = `level[i]`, or the gamma-corrected level when gamma is enabled.
  - Duty 0 gives an LED that is always off. Full duty gives an LED that is on for (2^PWM_BITS−1) of every 2^PWM_BITS cycles.
- No handshake: `pattern` is sampled every cycle and there is no backpressure.

## Timing
- **Reset values:** `div_cnt`, `pwm_cnt` and every `level[i]` are 0, and `led` and `tick` are 0. Reset takes effect immediately on assertion, including mid-fade or mid-PWM-period. After deassertion, all counters restart from 0.
- **Latency:** `pattern[i]` rising at edge k gives `level[i]` full at edge k+1. `led[i]` then reflects the new duty at edge k+2.
- **Fade duration:** a fade from full to 0 takes ceil((2^PWM_BITS−1)/DECAY_STEP) ticks. The first decrement happens on the first tick after `pattern[i]` falls.
- **Re-trigger:** if `pattern[i]` rises mid-fade, `level[i]` returns to full on the next edge.
- **Stuck high:** if `pattern[i]` stays high, `level[i]` holds at full indefinitely.
- **Independence:** `pwm_cnt` and `div_cnt` run independently of each other and of `pattern`.

## Configuration
- Macro: `LED_FADE_GAMMA_EN`.
- **Defined:** `duty[i] = (level[i] * level[i]) >> PWM_BITS`.
  - This is a combinational square-law map: 255 maps to 254, 128 to 64, and 1 to 0.
  - The product is computed at 2·PWM_BITS width, and the upper PWM_BITS bits are taken.
  - It adds no pipeline latency.
- **Undefined:** `duty[i] = level[i]`, giving linear brightness.
- **Unaffected either way:** `tick` and `level` behaviour.

## Structure
- **Package `led_fade_pkg`** holds:
  - defaults for `N_LEDS`, `PWM_BITS`, `DECAY_DIV` and `DECAY_STEP`;
  - the function computing the full-level constant;
  - the gamma function.
- **Sub-module `led_fade_chan`**: one instance per channel, created with a generate loop. Each instance holds `level`, the decay/saturation logic, the optional gamma stage and the comparator.
- **Top level** holds only the prescaler, `pwm_cnt` and the generate loop.

## Test plan
All tests use PWM_BITS=4, DECAY_DIV=4 and DECAY_STEP=5 unless stated.
- **Reset mid-fade:** assert `rst_n`=0 asynchronously between edges → `led` = 0 and `tick` = 0 immediately, with no clock needed. After deassertion, the first `tick` occurs on the 4th edge.
- **Full brightness:** `pattern` = 12'h001 held → `level[0]` = 15. `led[0]` is high 15 of every 16 cycles, starting 2 cycles after `pattern` rises. All other LEDs stay 0.
- **Decay sequence:** drop `pattern[0]` → `level[0]` steps 15→10→5→0 on 3 consecutive ticks, then stays 0. The duty cycle measured on `led[0]` follows 10/16, then 5/16, then 0.
- **Saturation:** DECAY_STEP=4 → level steps 15→11→7→3→0. The last step saturates; it never wraps to 15.
- **Tick vs re-trigger:** `pattern[0]` rises in the same cycle as `tick`, with `level` = 10 → `level` = 15 on the next edge, with no decrement.
- **Gamma:** with `LED_FADE_GAMMA_EN` defined and PWM_BITS=8, hold `level` at 128 → `led` is high 64 of every 256 cycles. At `level` = 255 → high 254 of every 256 cycles.
